// File: rtl/doorlock_pkg.sv
// doorlock_pkg: shared constants, state encoding and helpers for the
// door-lock passcode entry block (doorlock_entry_ctrl, doorlock_digit_buf).
package doorlock_pkg;

  // Width of one BCD digit in the edit buffer and stored passcode.
  localparam int DIGIT_W = 4;

  // Key codes delivered by the debounced switch front end.
  localparam logic [3:0] KEY_NONE  = 4'd0;
  localparam logic [3:0] KEY_CHDIG = 4'd1;
  localparam logic [3:0] KEY_NUMUP = 4'd2;
  localparam logic [3:0] KEY_A     = 4'd11;
  localparam logic [3:0] KEY_B     = 4'd12;

  // Lock controller states; exported on state_dbg for observation.
  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    SET_NEW  = 2'd2,
    ALARM    = 2'd3
  } state_t;

  // BCD increment of one digit: 9 wraps back to 0.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d == 4'd9) ? '0 : d + 4'd1;
  endfunction

  // Only these codes are meaningful; anything else never forms an event.
  function automatic logic is_key(input logic [3:0] k);
    return (k == KEY_CHDIG) || (k == KEY_NUMUP) || (k == KEY_A) || (k == KEY_B);
  endfunction

endpackage

// File: rtl/doorlock_digit_buf.sv
// doorlock_digit_buf: editable BCD digit buffer plus edit cursor.
// Strobes: clr (highest priority) zeroes digits and cursor; inc bumps the
// digit under the cursor; adv moves the cursor, wrapping at the last digit.
module doorlock_digit_buf
  import doorlock_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              inc,
  input  logic                              adv,
  input  logic                              clr,
  output logic [DIGIT_W*NUM_DIGITS-1:0]     digits,
  output logic [$clog2(NUM_DIGITS)-1:0]     cursor
);

  localparam int CW = $clog2(NUM_DIGITS);

  // Digit and cursor registers; clear wins over any edit in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      cursor <= '0;
    end else if (clr) begin
      digits <= '0;
      cursor <= '0;
    end else begin
      if (inc) begin
        digits[cursor*DIGIT_W +: DIGIT_W] <= bcd_inc(digits[cursor*DIGIT_W +: DIGIT_W]);
      end
      if (adv) begin
        cursor <= (cursor == CW'(NUM_DIGITS - 1)) ? '0 : cursor + CW'(1);
      end
    end
  end

endmodule

// File: rtl/doorlock_entry_ctrl.sv
// doorlock_entry_ctrl: door-lock passcode entry controller.
// key_code is a level held by the switch front end for many cycles; a key
// event is the first cycle a recognised nonzero code differs from the code
// seen on the previous cycle, so a held key acts once and a direct change
// from one code to another acts again. Outputs follow an event on the same
// clock edge that samples it.
// Optional build macro DOORLOCK_AUTOLOCK_EN: UNLOCKED relocks itself after
// UNLOCK_CYCLES without key events; without it UNLOCKED persists.
module doorlock_entry_ctrl
  import doorlock_pkg::*;
#(
  parameter int                            NUM_DIGITS    = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE  = '0,
  parameter int                            MAX_FAIL      = 3,
  parameter int                            ALARM_CYCLES  = 625_000_000,
  parameter int                            UNLOCK_CYCLES = 625_000_000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [3:0]                        key_code,
  output logic [DIGIT_W*NUM_DIGITS-1:0]     digits,
  output logic [$clog2(NUM_DIGITS)-1:0]     cursor,
  output logic                              unlocked,
  output logic                              alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
  output logic                              set_mode,
  output logic [1:0]                        state_dbg
);

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  state_t                        state, state_n;
  logic [3:0]                    key_q;
  logic                          key_ev;
  logic [FW-1:0]                 fail_n;
  logic [DIGIT_W*NUM_DIGITS-1:0] stored, stored_n;
  logic [AW-1:0]                 atmr, atmr_n;
  logic                          buf_inc, buf_adv, buf_clr;

`ifdef DOORLOCK_AUTOLOCK_EN
  localparam int UW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  logic [UW-1:0] utmr, utmr_n;
`else
  logic unused_unlock_cfg;
  assign unused_unlock_cfg = ^UNLOCK_CYCLES;
`endif

  assign key_ev = (key_code != KEY_NONE) && (key_code != key_q) && is_key(key_code);

  doorlock_digit_buf #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_digit_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (buf_inc),
    .adv    (buf_adv),
    .clr    (buf_clr),
    .digits (digits),
    .cursor (cursor)
  );

  // State, failure count, stored passcode, timers and the key history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENTRY;
      key_q    <= KEY_NONE;
      fail_cnt <= '0;
      stored   <= DEFAULT_CODE;
      atmr     <= '0;
`ifdef DOORLOCK_AUTOLOCK_EN
      utmr     <= '0;
`endif
    end else begin
      state    <= state_n;
      key_q    <= key_code;
      fail_cnt <= fail_n;
      stored   <= stored_n;
      atmr     <= atmr_n;
`ifdef DOORLOCK_AUTOLOCK_EN
      utmr     <= utmr_n;
`endif
    end
  end

  // Next-state, buffer edit strobes and bookkeeping for each lock state.
  always_comb begin
    state_n  = state;
    fail_n   = fail_cnt;
    stored_n = stored;
    atmr_n   = atmr;
    buf_inc  = 1'b0;
    buf_adv  = 1'b0;
    buf_clr  = 1'b0;
`ifdef DOORLOCK_AUTOLOCK_EN
    utmr_n   = '0;
`endif
    case (state)
      ENTRY: begin
        if (key_ev) begin
          case (key_code)
            KEY_NUMUP: buf_inc = 1'b1;
            KEY_CHDIG: buf_adv = 1'b1;
            KEY_A: begin
              buf_clr = 1'b1;
              if (digits == stored) begin
                state_n = UNLOCKED;
                fail_n  = '0;
              end else if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                state_n = ALARM;
                fail_n  = FW'(MAX_FAIL);
                atmr_n  = '0;
              end else begin
                fail_n  = fail_cnt + FW'(1);
              end
            end
            KEY_B:   buf_clr = 1'b1;
            default: ;
          endcase
        end
      end
      UNLOCKED: begin
        if (key_ev && key_code == KEY_A) begin
          state_n = ENTRY;
          buf_clr = 1'b1;
        end else if (key_ev && key_code == KEY_B) begin
          state_n = SET_NEW;
          buf_clr = 1'b1;
`ifdef DOORLOCK_AUTOLOCK_EN
        end else if (key_ev) begin
          // Ignored edit keys still count as activity and restart the timer.
          utmr_n = '0;
        end else if (utmr == UW'(UNLOCK_CYCLES - 1)) begin
          state_n = ENTRY;
          buf_clr = 1'b1;
        end else begin
          utmr_n = utmr + UW'(1);
`endif
        end
      end
      SET_NEW: begin
        if (key_ev) begin
          case (key_code)
            KEY_NUMUP: buf_inc = 1'b1;
            KEY_CHDIG: buf_adv = 1'b1;
            KEY_A: begin
              stored_n = digits;
              state_n  = ENTRY;
              buf_clr  = 1'b1;
            end
            KEY_B: begin
              state_n = UNLOCKED;
              buf_clr = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ALARM: begin
        // Keys are ignored and the buffer is pinned to zero until timeout.
        buf_clr = 1'b1;
        if (atmr == AW'(ALARM_CYCLES - 1)) begin
          state_n = ENTRY;
          fail_n  = '0;
          atmr_n  = '0;
        end else begin
          atmr_n = atmr + AW'(1);
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  assign unlocked  = (state == UNLOCKED) || (state == SET_NEW);
  assign alarm     = (state == ALARM);
  assign set_mode  = (state == SET_NEW);
  assign state_dbg = state;

endmodule

// File: tb/tb_doorlock_entry_ctrl.sv
// tb_doorlock_entry_ctrl: directed bench for doorlock_entry_ctrl.
// Expected output snapshots {digits,cursor,unlocked,alarm,fail_cnt,set_mode}
// are queued by the stimulus thread; a monitor compares them 1 time unit
// after each falling clock edge, when all registered outputs are stable.
module tb_doorlock_entry_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int VW         = 23;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [1:0]  cursor;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  fail_cnt;
  logic        set_mode;
  logic [1:0]  state_dbg;

  logic [VW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  doorlock_entry_ctrl #(
    .NUM_DIGITS    (NUM_DIGITS),
    .DEFAULT_CODE  (16'h0021),
    .MAX_FAIL      (3),
    .ALARM_CYCLES  (50),
    .UNLOCK_CYCLES (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .digits    (digits),
    .cursor    (cursor),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt),
    .set_mode  (set_mode),
    .state_dbg (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic expect_out(input string nm, input logic [15:0] d, input logic [1:0] c,
                            input logic u, input logic a, input logic [1:0] f, input logic s);
    exp_q.push_back({d, c, u, a, f, s});
    name_q.push_back(nm);
  endtask

  // Hold a code for one cycle, then release to 0.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_code = code;
    @(negedge clk);
    key_code = 4'd0;
  endtask

  // Key in a full passcode digit by digit; cursor ends back at 0.
  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic [3:0] dg;
      dg = code[4*i +: 4];
      repeat (int'(dg)) press(4'd2);
      press(4'd1);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [VW-1:0] exp_v;
    logic [VW-1:0] act_v;
    string         nm;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {digits, cursor, unlocked, alarm, fail_cnt, set_mode};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s: actual digits=%h cur=%0d unl=%b alm=%b fail=%0d set=%b, required digits=%h cur=%0d unl=%b alm=%b fail=%0d set=%b",
                   nm, act_v[22:7], act_v[6:5], act_v[4], act_v[3], act_v[2:1], act_v[0],
                   exp_v[22:7], exp_v[6:5], exp_v[4], exp_v[3], exp_v[2:1], exp_v[0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    key_code = 4'd0;
    @(negedge clk);
    expect_out("reset", 16'h0000, 2'd0, 0, 0, 2'd0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Held key increments exactly once; then wrap 9 -> 0.
    @(negedge clk);
    key_code = 4'd2;
    repeat (1000) @(negedge clk);
    expect_out("held_once", 16'h0001, 2'd0, 0, 0, 2'd0, 0);
    key_code = 4'd0;
    repeat (8) press(4'd2);
    expect_out("digit_nine", 16'h0009, 2'd0, 0, 0, 2'd0, 0);
    press(4'd2);
    expect_out("digit_wrap", 16'h0000, 2'd0, 0, 0, 2'd0, 0);

    // Correct entry of 0021.
    press(4'd2); press(4'd1); press(4'd2); press(4'd2);
    expect_out("entry_buf", 16'h0021, 2'd1, 0, 0, 2'd0, 0);
    press(4'd11);
    expect_out("unlock", 16'h0000, 2'd0, 1, 0, 2'd0, 0);
    press(4'd2); press(4'd1);
    expect_out("unl_ignore", 16'h0000, 2'd0, 1, 0, 2'd0, 0);
    press(4'd11);
    expect_out("relock", 16'h0000, 2'd0, 0, 0, 2'd0, 0);

    // Three wrong submits -> alarm for exactly 50 cycles.
    press(4'd11);
    expect_out("wrong1", 16'h0000, 2'd0, 0, 0, 2'd1, 0);
    press(4'd11);
    expect_out("wrong2", 16'h0000, 2'd0, 0, 0, 2'd2, 0);
    press(4'd11);
    expect_out("alarm_on", 16'h0000, 2'd0, 0, 1, 2'd3, 0);
    press(4'd2); press(4'd1); press(4'd11);
    expect_out("alarm_ignore", 16'h0000, 2'd0, 0, 1, 2'd3, 0);
    repeat (43) @(negedge clk);
    expect_out("alarm_last", 16'h0000, 2'd0, 0, 1, 2'd3, 0);
    @(negedge clk);
    expect_out("alarm_end", 16'h0000, 2'd0, 0, 0, 2'd0, 0);

    // Change passcode to 0003.
    enter_code(16'h0021);
    press(4'd11);
    expect_out("unlock2", 16'h0000, 2'd0, 1, 0, 2'd0, 0);
    press(4'd12);
    expect_out("set_new", 16'h0000, 2'd0, 1, 0, 2'd0, 1);
    repeat (3) press(4'd2);
    expect_out("new_buf", 16'h0003, 2'd0, 1, 0, 2'd0, 1);
    press(4'd11);
    expect_out("new_saved", 16'h0000, 2'd0, 0, 0, 2'd0, 0);
    enter_code(16'h0021);
    press(4'd11);
    expect_out("old_code_fails", 16'h0000, 2'd0, 0, 0, 2'd1, 0);
    enter_code(16'h0003);
    press(4'd11);
    expect_out("new_code_ok", 16'h0000, 2'd0, 1, 0, 2'd0, 0);
    press(4'd11);
    expect_out("lock_again", 16'h0000, 2'd0, 0, 0, 2'd0, 0);

    // Back-to-back codes and unrecognised codes.
    @(negedge clk); key_code = 4'd2;
    @(negedge clk); key_code = 4'd1;
    @(negedge clk); key_code = 4'd0;
    expect_out("b2b", 16'h0001, 2'd1, 0, 0, 2'd0, 0);
    press(4'd13); press(4'd15);
    expect_out("ignore_13_15", 16'h0001, 2'd1, 0, 0, 2'd0, 0);
    @(negedge clk); key_code = 4'd2;
    @(negedge clk); key_code = 4'd13;
    @(negedge clk); key_code = 4'd2;
    @(negedge clk); key_code = 4'd0;
    expect_out("code13_between", 16'h0021, 2'd1, 0, 0, 2'd0, 0);
    press(4'd12);
    expect_out("mode_clear", 16'h0000, 2'd0, 0, 0, 2'd0, 0);

    // Relock timer behaviour.
    enter_code(16'h0003);
    press(4'd11);
    expect_out("unlock3", 16'h0000, 2'd0, 1, 0, 2'd0, 0);
`ifdef DOORLOCK_AUTOLOCK_EN
    repeat (99) @(negedge clk);
    expect_out("autolock_hold", 16'h0000, 2'd0, 1, 0, 2'd0, 0);
    @(negedge clk);
    expect_out("autolock", 16'h0000, 2'd0, 0, 0, 2'd0, 0);
`else
    repeat (1000) @(negedge clk);
    expect_out("no_autolock", 16'h0000, 2'd0, 1, 0, 2'd0, 0);
    press(4'd11);
    expect_out("lock3", 16'h0000, 2'd0, 0, 0, 2'd0, 0);
`endif

    // Asynchronous reset in the middle of an alarm.
    repeat (3) press(4'd11);
    expect_out("alarm_again", 16'h0000, 2'd0, 0, 1, 2'd3, 0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_out("async_reset", 16'h0000, 2'd0, 0, 0, 2'd0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Stored code is back to the default after reset.
    enter_code(16'h0021);
    press(4'd11);
    expect_out("default_restored", 16'h0000, 2'd0, 1, 0, 2'd0, 0);

    // ---------------- final report ----------------
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/doorlock_entry_ctrl.md
Name: doorlock_entry_ctrl

Overview:
- Consumes the 4-bit key-code stream from the debounced switch front end and implements door-lock passcode entry.
- Holds an editable BCD digit buffer and a cursor, and compares the buffer against a stored passcode on submit.
- Drives lock, unlock and alarm status.
- Sits directly downstream of the switch interface; its digit and cursor outputs feed the display driver.

Parameters:
- NUM_DIGITS, 4, passcode length in BCD digits (>=2).
- DEFAULT_CODE, 16'h0000, passcode after reset; digit i at bits [4i+3:4i].
- MAX_FAIL, 3, consecutive wrong submits that trigger the alarm (>=1).
- ALARM_CYCLES, 625_000_000, alarm hold time in clk cycles.
- UNLOCK_CYCLES, 625_000_000, auto-relock timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_code  in  4  0=none, 1=change digit, 2=number up, 11=switch A (enter), 12=switch B (mode); held for many cycles
- digits  out  4*NUM_DIGITS  BCD edit buffer, for display
- cursor  out  $clog2(NUM_DIGITS)  index of the digit being edited
- unlocked  out  1  high in UNLOCKED and SET_NEW
- alarm  out  1  high in ALARM
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed submits
- set_mode  out  1  high in SET_NEW

Behaviour:
- Reset (async, rst_n=0):
  - state=ENTRY; digits=0; cursor=0; fail_cnt=0; stored code=DEFAULT_CODE.
  - unlocked=0, alarm=0, set_mode=0; timers=0; key_q=0.
- Event detection:
  - key_q registers key_code every cycle.
  - A key event occurs in a cycle where key_code!=0 and key_code!=key_q. A held code yields exactly one event.
  - Back-to-back different codes (2 then 1 with no 0 between) yield two events.
  - Codes other than 1, 2, 11, 12 produce no event and leave key_q updating normally.
- Latency: outputs reflect an event on the clk edge that samples it (1 cycle).
- Edit rules (ENTRY and SET_NEW):
  - Code 2 increments digits[cursor]; 9 wraps to 0.
  - Code 1 advances cursor; NUM_DIGITS-1 wraps to 0.
- State ENTRY:
  - Code 11, buffer==stored: ->UNLOCKED, fail_cnt=0.
  - Code 11, mismatch, fail_cnt+1==MAX_FAIL: ->ALARM, fail_cnt=MAX_FAIL, alarm timer=0.
  - Code 11, other mismatch: fail_cnt+1, stay in ENTRY.
  - Any submit clears the buffer and sets cursor=0.
  - Code 12: clear buffer and cursor; fail_cnt unchanged.
- State UNLOCKED:
  - Code 11: ->ENTRY, buffer cleared.
  - Code 12: ->SET_NEW, buffer cleared, cursor=0.
  - Codes 1 and 2 are ignored.
- State SET_NEW:
  - Code 11: stored code<=buffer, ->ENTRY (locked), buffer cleared.
  - Code 12: cancel, ->UNLOCKED, stored code unchanged.
- State ALARM:
  - All key events are ignored; the buffer is held at 0.
  - Timer counts 0..ALARM_CYCLES-1; at terminal count ->ENTRY, fail_cnt=0.
- Reset mid-operation: immediate return to reset values; a stored code changed via SET_NEW reverts to DEFAULT_CODE.
- All compares are full-width; no partial-match state.

Optional Feature:
- Macro DOORLOCK_AUTOLOCK_EN.
- Defined:
  - UNLOCKED runs a relock timer that resets on entering UNLOCKED and on any key event while UNLOCKED.
  - At UNLOCK_CYCLES-1 the block goes to ENTRY with the buffer cleared.
  - SET_NEW is not timed.
- Undefined: no timer; UNLOCKED persists until code 11 or 12.

Decomposition:
- Package doorlock_pkg holds:
  - key code constants KEY_NONE=0, KEY_CHDIG=1, KEY_NUMUP=2, KEY_A=11, KEY_B=12;
  - the state enum ENTRY/UNLOCKED/SET_NEW/ALARM;
  - the BCD digit width constant 4.
- Sub-module doorlock_digit_buf holds the digit registers and the cursor. It has inc, adv and clr strobes and outputs digits and cursor, and is instantiated once.
- The FSM, timers, comparator and event detector live in the top level.

Test Plan (NUM_DIGITS=4, DEFAULT_CODE=16'h0021, MAX_FAIL=3, ALARM_CYCLES=50, UNLOCK_CYCLES=100):
- Code 2 held 1000 cycles -> digits[3:0]=1 exactly once. Then 2,0,2,0,...: ten increments -> digit back to 0.
- Correct entry:
  - Stimulus: 2,0; 1,0; 2,0; 2,0; then 11.
  - Required response: unlocked=1 one cycle after the 11 event, digits=0, fail_cnt=0.
- Three wrong submits of 0000:
  - Required response: fail_cnt 1, 2, then alarm=1 and fail_cnt=3.
  - Key events during ALARM are ignored.
  - Alarm drops after 50 cycles, with fail_cnt=0.
- Change passcode:
  - Stimulus: unlock, then 12, then key in 16'h0003, then 11.
  - Required response: locked; submitting 0021 fails; submitting 0003 unlocks.
- Timer checks:
  - With DOORLOCK_AUTOLOCK_EN: unlocked -> no keys for 100 cycles -> unlocked=0.
  - Without the macro: unlocked is still 1 after 1000 cycles.
- Reset checks:
  - rst_n pulsed low mid-ALARM -> all outputs at reset values asynchronously.
  - Stored code reverts to 16'h0021.
  - Code 13 and code 15 events -> no output change.
